// File: rtl/mul_border_multi_if.sv
// Start/busy/done bus for the multi-channel border multiplier.
// The o_cnt signal exists only when MUL_BORDER_ACC_EN is defined.
interface mul_border_multi_if #(
  parameter int WIDTH = 16,
  parameter int CH    = 4,
  parameter int LW    = $clog2(WIDTH)
);
  logic                     start;
  logic [WIDTH-2:0]         i_data_i;
  logic [CH*(WIDTH-1)-1:0]  i_data_w;
  logic [LW-1:0]            i_len_log;
  logic                     busy;
  logic                     done;
  logic                     o_valid;
  logic [CH-1:0]            o_bit;
  logic                     i_bit_d;
`ifdef MUL_BORDER_ACC_EN
  logic [CH*WIDTH-1:0]      o_cnt;

  modport master (
    output start, i_data_i, i_data_w, i_len_log,
    input  busy, done, o_valid, o_bit, i_bit_d, o_cnt
  );
  modport slave (
    input  start, i_data_i, i_data_w, i_len_log,
    output busy, done, o_valid, o_bit, i_bit_d, o_cnt
  );
`else
  modport master (
    output start, i_data_i, i_data_w, i_len_log,
    input  busy, done, o_valid, o_bit, i_bit_d
  );
  modport slave (
    input  start, i_data_i, i_data_w, i_len_log,
    output busy, done, o_valid, o_bit, i_bit_d
  );
`endif
endinterface

// File: rtl/mul_border_multi.sv
// Unary-rate border multiplier: one input stream gating a shared weight RNG.
// Optional per-channel ones counters are enabled by MUL_BORDER_ACC_EN.
module mul_border_multi #(
  parameter int WIDTH = 16,
  parameter int CH    = 4,
  parameter int LW    = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst,
  mul_border_multi_if.slave bus
);
  localparam int M = WIDTH - 1;
  localparam logic [LW:0] LMAX = (LW+1)'(M);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST
  } state_t;

  state_t          r_state;
  logic [M-1:0]    r_di;
  logic [CH*M-1:0] r_w;
  logic [M-1:0]    r_last;
  logic [M-1:0]    r_icnt;
  logic [M-1:0]    r_wcnt;
  logic            r_busy;
  logic            r_done;
  logic            r_valid;
  logic [CH-1:0]   r_obit;
  logic            r_ibit;

  logic [LW:0]     w_len;
  logic [M-1:0]    w_mask;
  logic [M-1:0]    w_rng_i;
  logic [M-1:0]    w_rng_w;
  logic            w_bi;
  logic [CH-1:0]   w_bw;

  function automatic logic [M-1:0] f_rev(
    input logic [M-1:0] x
  );
    logic [M-1:0] r;
    for (int i = 0; i < M; i++) begin
      r[i] = x[M-1-i];
    end
    return r;
  endfunction

  // Last index of the run is 2^L-1, with L clamped to M.
  always_comb begin
    w_len = {1'b0, bus.i_len_log};
    if (w_len > LMAX) begin
      w_len = LMAX;
    end
    w_mask = {M{1'b1}} >> (LMAX - w_len);
  end

  always_comb begin
    w_rng_i = f_rev(r_icnt);
    w_rng_w = f_rev(r_wcnt);
    w_bi    = r_di > w_rng_i;
    for (int c = 0; c < CH; c++) begin
      w_bw[c] = r_w[c*M +: M] > w_rng_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_di    <= '0;
      r_w     <= '0;
      r_last  <= '0;
      r_icnt  <= '0;
      r_wcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_obit  <= '0;
      r_ibit  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          r_obit  <= '0;
          r_ibit  <= 1'b0;
          if (bus.start) begin
            r_di    <= bus.i_data_i;
            r_w     <= bus.i_data_w;
            r_last  <= w_mask;
            r_icnt  <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_valid <= 1'b1;
          r_ibit  <= w_bi;
          r_obit  <= w_bw & {CH{w_bi}};
          r_icnt  <= r_icnt + 1'b1;
          if (w_bi) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
          if (r_icnt == r_last) begin
            r_done  <= 1'b1;
            r_state <= S_LAST;
          end
        end
        S_LAST: begin
          r_done  <= 1'b0;
          r_valid <= 1'b0;
          r_obit  <= '0;
          r_ibit  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.o_valid = r_valid;
  assign bus.o_bit   = r_obit;
  assign bus.i_bit_d = r_ibit;

`ifdef MUL_BORDER_ACC_EN
  logic [CH*WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_cnt <= '0;
    end else if (r_valid) begin
      for (int c = 0; c < CH; c++) begin
        if (r_obit[c]) begin
          r_cnt[c*WIDTH +: WIDTH] <= r_cnt[c*WIDTH +: WIDTH] + 1'b1;
        end
      end
    end
  end

  assign bus.o_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_mul_border_multi.sv
// Scoreboard bench for mul_border_multi: random and directed runs
// checked against a stream-level reference model.
module tb_mul_border_multi;
  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int LW    = $clog2(WIDTH);
  localparam int M     = WIDTH - 1;

  typedef struct packed {
    logic          ib;
    logic [CH-1:0] ob;
    logic          dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ones_i = 0;
  bit   mon_en = 1'b1;
  int   exp_cnt[CH];
  exp_t q[$];

  mul_border_multi_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

  mul_border_multi #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    for (int i = 0; i < M; i++) begin
      r = r * 2 + ((x >> i) & 1);
    end
    return r;
  endfunction

  // Stream-level model: push one expected item per output bit.
  task automatic model(input logic [M-1:0] di, input logic [CH*M-1:0] w, input int n);
    int wc = 0;
    for (int c = 0; c < CH; c++) exp_cnt[c] = 0;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int ri = rev(k);
      int rw = rev(wc);
      e.ib = int'(di) > ri;
      for (int c = 0; c < CH; c++) begin
        e.ob[c] = e.ib && (int'(w[c*M +: M]) > rw);
        exp_cnt[c] += int'(e.ob[c]);
      end
      e.dn = (k == n - 1);
      if (e.ib) wc++;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) begin
        if (mon_en) begin
          if (q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("i_bit_d", bus.i_bit_d, e.ib);
            chk("o_bit", bus.o_bit, e.ob);
            chk("done", bus.done, e.dn);
          end
          ones_i += int'(bus.i_bit_d);
        end
      end else begin
        chk("invalid_zero", {bus.o_bit, bus.i_bit_d, bus.done}, 0);
      end
    end
  end

  function automatic logic [CH*M-1:0] rand_w();
    logic [CH*M-1:0] w;
    for (int c = 0; c < CH; c++) w[c*M +: M] = M'($urandom);
    return w;
  endfunction

  // Called at a negedge; leaves the bench at the negedge of cycle N+2.
  task automatic run(input logic [M-1:0] di, input logic [CH*M-1:0] w,
                     input int len, input bit hold, input bit poke);
    int n = 1 << ((len > M) ? M : len);
    int k = 0;
    bit seen = 1'b0;
    model(di, w, n);
    ones_i = 0;
    bus.start     = 1'b1;
    bus.i_data_i  = di;
    bus.i_data_w  = w;
    bus.i_len_log = LW'(len);
    while (!seen && k < n + 4) begin
      @(negedge clk);
      k++;
      if (k == 1 && !hold) bus.start = 1'b0;
      if (poke && n >= 4 && k == 3) begin
        bus.start     = 1'b1;
        bus.i_data_i  = ~di;
        bus.i_data_w  = ~w;
        bus.i_len_log = '0;
      end
      if (poke && n >= 4 && k == 4) begin
        bus.start     = 1'b0;
        bus.i_data_i  = di;
        bus.i_data_w  = w;
        bus.i_len_log = LW'(len);
      end
      if (k <= n + 1) chk("busy_run", bus.busy, 1);
      if (bus.done) seen = 1'b1;
    end
    chk("done_cycle", k, n + 1);
    @(negedge clk);
    chk("busy_gap", bus.busy, 0);
    chk("valid_gap", bus.o_valid, 0);
`ifdef MUL_BORDER_ACC_EN
    for (int c = 0; c < CH; c++) begin
      chk("o_cnt", bus.o_cnt[c*WIDTH +: WIDTH], exp_cnt[c]);
    end
`endif
  endtask

  task automatic chk_cnt(input string nm, input int c, input int v);
`ifdef MUL_BORDER_ACC_EN
    chk(nm, bus.o_cnt[c*WIDTH +: WIDTH], v);
`endif
  endtask

  task automatic abort_run();
    mon_en        = 1'b0;
    bus.start     = 1'b1;
    bus.i_data_i  = M'(16384);
    bus.i_data_w  = {CH{M'(32767)}};
    bus.i_len_log = LW'(4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      chk("abort_nodone", bus.done, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_obit", bus.o_bit, 0);
    chk("abort_ibit", bus.i_bit_d, 0);
    for (int c = 0; c < CH; c++) chk_cnt("abort_cnt", c, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.i_data_i  = '0;
    bus.i_data_w  = '0;
    bus.i_len_log = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_obit", bus.o_bit, 0);
    chk("rst_ibit", bus.i_bit_d, 0);
    for (int c = 0; c < CH; c++) chk_cnt("rst_cnt", c, 0);
    rst = 1'b0;
    @(negedge clk);

    run(M'(16384), {M'(8192), M'(16384), M'(0), M'(32767)}, 4, 0, 0);
    chk("t2_ones_i", ones_i, 8);
    chk_cnt("t2_cnt0", 0, 8);
    chk_cnt("t2_cnt1", 1, 0);
    chk_cnt("t2_cnt2", 2, 4);
    chk_cnt("t2_cnt3", 3, 2);

    run(M'(1), {CH{M'(1)}}, 0, 0, 0);
    chk("l0_ones_i", ones_i, 1);
    for (int c = 0; c < CH; c++) chk_cnt("l0_cnt", c, 1);

    run(M'($urandom), rand_w(), 3, 1, 0);
    run(M'($urandom), rand_w(), 3, 0, 0);

    run(M'($urandom), rand_w(), 5, 0, 1);

    run(M'(0), rand_w(), 6, 0, 0);
    for (int c = 0; c < CH; c++) chk_cnt("zero_cnt", c, 0);

    abort_run();
    run(M'(16384), {CH{M'(32767)}}, 4, 0, 0);
    chk_cnt("post_abort_cnt0", 0, 8);

    for (int i = 0; i < 25; i++) begin
      run(M'($urandom), rand_w(), $urandom_range(0, 6),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;
    @(negedge clk);

    run(M'(16384), {CH{M'(16384)}}, 15, 0, 0);
    chk("t1_ones_i", ones_i, 16384);
    for (int c = 0; c < CH; c++) chk_cnt("t1_cnt", c, 8192);

    run(M'(32767), {rand_w() >> M, M'(32767)}, 15, 0, 0);
    chk_cnt("t3_cnt0", 0, 32767);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
